// File: rtl/imm_gen_pfx.sv
// imm_gen_pfx: registered immediate generator with a one-shot prefix register.
// Four extension modes (sign short, sign long, zero long, upper). A prefix
// instruction supplies the upper DATA_W-IMM_L_W bits, and the next consuming
// latch merges them with its long field.
// Optional build macro: IMM_GEN_PFX_TIMEOUT_EN makes a pending prefix expire
// after PFX_TIMEOUT cycles in PEND, which raises Pfx_Err.
module imm_gen_pfx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned IMM_S_W     = 4,
  parameter int unsigned IMM_L_W     = 8,
  parameter int unsigned PFX_TIMEOUT = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [1:0]         Imm_Sel,
  input  logic               Imm_Latch,
  input  logic               Pfx_Load,
  input  logic               Pfx_Flush,
  output logic [DATA_W-1:0]  Imm_Out,
  output logic               Pfx_Valid,
  output logic               Pfx_Err
);

  localparam int unsigned PFX_W = DATA_W - IMM_L_W;

  localparam logic [1:0] SEL_SSHORT = 2'b00;
  localparam logic [1:0] SEL_SLONG  = 2'b01;
  localparam logic [1:0] SEL_ZLONG  = 2'b10;
  localparam logic [1:0] SEL_UPPER  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_c;
  logic [PFX_W-1:0]   pfx_q;
  logic [DATA_W-1:0]  imm_c;
  logic               pend_c;
  logic               take_pfx_c;
  logic               misuse_c;
  logic               expire_c;

  assign pend_c     = (state_q == PEND);
  assign take_pfx_c = Pfx_Load && !Pfx_Flush;

  // A mode-11 latch over a pending prefix, or reloading a prefix nobody consumed
  assign misuse_c = (Imm_Latch && pend_c && (Imm_Sel == SEL_UPPER)) ||
                    (Pfx_Load && pend_c && !Imm_Latch);

`ifdef IMM_GEN_PFX_TIMEOUT_EN
  localparam int unsigned TMR_W = (PFX_TIMEOUT > 1) ? $clog2(PFX_TIMEOUT) : 1;

  logic [TMR_W-1:0] tmr_q;

  // Expiry only when nothing else resolves the prefix this cycle
  assign expire_c = pend_c && (tmr_q == TMR_W'(PFX_TIMEOUT - 1)) &&
                    !Imm_Latch && !Pfx_Flush && !Pfx_Load;

  // Prefix age: cleared on every (re)load, counts while pending
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmr_q <= '0;
    end else if (take_pfx_c) begin
      tmr_q <= '0;
    end else if (pend_c) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end
`else
  logic unused_timeout_c;

  assign expire_c         = 1'b0;
  assign unused_timeout_c = ^{32'(PFX_TIMEOUT)};
`endif

  logic unused_instr_c;
  assign unused_instr_c = ^{Instr[INSTR_W-1:IMM_L_W]};

  // Immediate selection; a pending prefix replaces the extension except in mode 11
  always_comb begin
    imm_c = '0;
    if (pend_c && (Imm_Sel != SEL_UPPER)) begin
      imm_c = {pfx_q, Instr[IMM_L_W-1:0]};
    end else begin
      case (Imm_Sel)
        SEL_SSHORT: imm_c = {{(DATA_W-IMM_S_W){Instr[IMM_S_W-1]}}, Instr[IMM_S_W-1:0]};
        SEL_SLONG:  imm_c = {{(DATA_W-IMM_L_W){Instr[IMM_L_W-1]}}, Instr[IMM_L_W-1:0]};
        SEL_ZLONG:  imm_c = {{(DATA_W-IMM_L_W){1'b0}}, Instr[IMM_L_W-1:0]};
        default:    imm_c = {Instr[IMM_L_W-1:0], {PFX_W{1'b0}}};
      endcase
    end
  end

  // Prefix FSM next state: flush wins, then load, then consume/expire
  always_comb begin
    state_c = state_q;
    case (state_q)
      IDLE: begin
        if (take_pfx_c) begin
          state_c = PEND;
        end
      end
      PEND: begin
        if (Pfx_Flush) begin
          state_c = IDLE;
        end else if (Pfx_Load) begin
          state_c = PEND;
        end else if (Imm_Latch || expire_c) begin
          state_c = IDLE;
        end
      end
      default: state_c = IDLE;
    endcase
  end

  // State, prefix payload and all registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      pfx_q     <= '0;
      Imm_Out   <= '0;
      Pfx_Valid <= 1'b0;
      Pfx_Err   <= 1'b0;
    end else begin
      state_q   <= state_c;
      Pfx_Valid <= (state_c == PEND);
      if (Imm_Latch) begin
        Imm_Out <= imm_c;
      end
      if (take_pfx_c) begin
        pfx_q <= Instr[PFX_W-1:0];
      end
      if (Pfx_Flush) begin
        Pfx_Err <= 1'b0;
      end else if (misuse_c || expire_c) begin
        Pfx_Err <= 1'b1;
      end
    end
  end

endmodule
